// File: rtl/fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_pkg
// Shared definitions for the fetch controller: controller state encoding,
// PC mux select encodings and the default boot length.
// -----------------------------------------------------------------------------
package fetch_ctrl_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // PC mux select encodings
    localparam logic [1:0] PC_SEL_RESET = 2'd0;  // RESET_PC
    localparam logic [1:0] PC_SEL_HOLD  = 2'd1;  // PC_reg_out
    localparam logic [1:0] PC_SEL_PC4   = 2'd2;  // PC + 4
    localparam logic [1:0] PC_SEL_ALU   = 2'd3;  // ALU_result

    // Default number of cycles spent in BOOT after reset release
    localparam int unsigned BOOT_CYCLES_DEF = 32'd2;

endpackage : fetch_ctrl_pkg

// File: rtl/fetch_perf_cnt.sv
// -----------------------------------------------------------------------------
// fetch_perf_cnt
// Free-running CNT_W-bit event counter; wraps modulo 2^CNT_W.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset (count -> 0)
//   clr   - synchronous clear, wins over a same-cycle increment
//   inc   - count enable for this cycle
//   cnt   - registered count value
// -----------------------------------------------------------------------------
module fetch_perf_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear has priority over increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (inc) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule : fetch_perf_cnt

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Fetch-stage controller: sequences BOOT -> RUN <-> HALT, drives the PC mux
// select, the flush (should_br) and fetch_valid, and keeps three performance
// counters (cycles out of BOOT, accepted instructions, flushes).
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   redirect, stall          - execute-stage redirect / pipeline stall
//   halt, resume             - HALT entry / exit requests
//   counter_clr              - synchronous clear of all counters
//   PC_sel                   - 0 RESET_PC, 1 hold, 2 PC+4, 3 ALU_result
//   should_br                - flush the instruction fetched this cycle
//   fetch_valid              - instruction leaving fetch is accepted
//   cycle_cnt/inst_cnt/flush_cnt - CNT_W-bit wrapping counters
// -----------------------------------------------------------------------------
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned BOOT_CYCLES = BOOT_CYCLES_DEF,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect,
    input  logic             stall,
    input  logic             halt,
    input  logic             resume,
    input  logic             counter_clr,
    output logic [1:0]       PC_sel,
    output logic             should_br,
    output logic             fetch_valid,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] inst_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [7:0] BOOT_LOAD = 8'(BOOT_CYCLES - 32'd1);

    state_e     state_q;
    state_e     state_d;
    logic [7:0] boot_cnt_q;
    logic [7:0] boot_cnt_d;

    // State register and boot down-counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= BOOT_LOAD;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
        end
    end

    // Next-state and output decode; reset forces the safe (BOOT-like) outputs
    // even in the cycle where the state register still holds RUN or HALT.
    always_comb begin
        state_d     = state_q;
        boot_cnt_d  = boot_cnt_q;
        PC_sel      = PC_SEL_RESET;
        should_br   = 1'b0;
        fetch_valid = 1'b0;
        if (rst) begin
            state_d    = ST_BOOT;
            boot_cnt_d = BOOT_LOAD;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    if (boot_cnt_q == 8'd0) begin
                        state_d = ST_RUN;
                    end else begin
                        boot_cnt_d = boot_cnt_q - 8'd1;
                    end
                end
                ST_RUN: begin
                    if (redirect) begin
                        // Redirect wins; a simultaneous halt is retried next cycle
                        PC_sel    = PC_SEL_ALU;
                        should_br = 1'b1;
                    end else begin
                        if (stall) begin
                            PC_sel = PC_SEL_HOLD;
                        end else begin
                            PC_sel      = PC_SEL_PC4;
                            fetch_valid = 1'b1;
                        end
                        if (halt) begin
                            state_d = ST_HALT;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_HALT: begin
                    PC_sel = PC_SEL_HOLD;
                    if (resume) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_HALT;
                    end
                end
                default: begin
                    state_d    = ST_BOOT;
                    boot_cnt_d = BOOT_LOAD;
                end
            endcase
        end
    end

    logic cycle_inc_s;
    assign cycle_inc_s = (state_q != ST_BOOT);

    fetch_perf_cnt #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .clr (counter_clr),
        .inc (cycle_inc_s),
        .cnt (cycle_cnt)
    );

    fetch_perf_cnt #(.CNT_W(CNT_W)) u_inst_cnt (
        .clk (clk),
        .rst (rst),
        .clr (counter_clr),
        .inc (fetch_valid),
        .cnt (inst_cnt)
    );

    fetch_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .clr (counter_clr),
        .inc (should_br),
        .cnt (flush_cnt)
    );

endmodule : fetch_ctrl

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Directed bench for fetch_ctrl. Inputs change 1 time unit after a rising edge
// and outputs are sampled 2 units later, well clear of the next edge.
// dut  : BOOT_CYCLES=2, CNT_W=32
// dut4 : BOOT_CYCLES=2, CNT_W=4 (counter wrap scenario)
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst, redirect, stall, halt, resume, counter_clr;
    logic [1:0]  pc_sel;
    logic        should_br, fetch_valid;
    logic [31:0] cycle_cnt, inst_cnt, flush_cnt;

    logic        rst4, redirect4, stall4, halt4, resume4, clr4;
    logic [1:0]  pc_sel4;
    logic        should_br4, fetch_valid4;
    logic [3:0]  cycle_cnt4, inst_cnt4, flush_cnt4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.BOOT_CYCLES(2), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .stall(stall), .halt(halt),
        .resume(resume), .counter_clr(counter_clr), .PC_sel(pc_sel),
        .should_br(should_br), .fetch_valid(fetch_valid),
        .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt), .flush_cnt(flush_cnt)
    );

    fetch_ctrl #(.BOOT_CYCLES(2), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst4), .redirect(redirect4), .stall(stall4), .halt(halt4),
        .resume(resume4), .counter_clr(clr4), .PC_sel(pc_sel4),
        .should_br(should_br4), .fetch_valid(fetch_valid4),
        .cycle_cnt(cycle_cnt4), .inst_cnt(inst_cnt4), .flush_cnt(flush_cnt4)
    );

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        redirect = 1'b0; stall = 1'b0; halt = 1'b0; resume = 1'b0; counter_clr = 1'b0;
    endtask

    // Reset then walk through BOOT; returns in the first RUN cycle, counters 0
    task automatic boot();
        idle_inputs();
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        cyc(); cyc();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        cyc(); cyc(); cyc();
        #2;
        checks++; if (pc_sel !== 2'd0) begin failures++; $display("FAIL rst_pc_sel: got %0d want 0", pc_sel); end
        checks++; if (fetch_valid !== 1'b0 || should_br !== 1'b0) begin failures++; $display("FAIL rst_flags: fv=%0b br=%0b want 0 0", fetch_valid, should_br); end
        checks++; if (cycle_cnt !== 32'd0 || inst_cnt !== 32'd0 || flush_cnt !== 32'd0) begin failures++; $display("FAIL rst_counters: %0d %0d %0d want 0 0 0", cycle_cnt, inst_cnt, flush_cnt); end
        rst = 1'b0;
        #2;
        checks++; if (pc_sel !== 2'd0) begin failures++; $display("FAIL boot_c0_pc_sel: got %0d want 0", pc_sel); end
        cyc(); #2;
        checks++; if (pc_sel !== 2'd0) begin failures++; $display("FAIL boot_c1_pc_sel: got %0d want 0", pc_sel); end
        checks++; if (cycle_cnt !== 32'd0) begin failures++; $display("FAIL boot_cycle_cnt: got %0d want 0", cycle_cnt); end
        cyc(); #2;
        checks++; if (pc_sel !== 2'd2 || fetch_valid !== 1'b1) begin failures++; $display("FAIL boot_run_first: pc_sel=%0d fv=%0b want 2 1", pc_sel, fetch_valid); end
        cyc(); #2;
        checks++; if (cycle_cnt !== 32'd1) begin failures++; $display("FAIL boot_cycle_cnt_run: got %0d want 1", cycle_cnt); end
        checks++; if (inst_cnt !== 32'd1) begin failures++; $display("FAIL boot_inst_cnt_run: got %0d want 1", inst_cnt); end
    endtask

    task automatic test_redirect_vs_stall();
        boot();
        redirect = 1'b1; stall = 1'b1;
        #2;
        checks++; if (pc_sel !== 2'd3 || should_br !== 1'b1 || fetch_valid !== 1'b0) begin failures++; $display("FAIL redir_prio: pc_sel=%0d br=%0b fv=%0b want 3 1 0", pc_sel, should_br, fetch_valid); end
        cyc();
        redirect = 1'b0; stall = 1'b0;
        #2;
        checks++; if (flush_cnt !== 32'd1 || inst_cnt !== 32'd0) begin failures++; $display("FAIL redir_counts: flush=%0d inst=%0d want 1 0", flush_cnt, inst_cnt); end
        checks++; if (pc_sel !== 2'd2) begin failures++; $display("FAIL redir_after: pc_sel=%0d want 2", pc_sel); end
        // halt together with redirect: redirect wins, state stays RUN
        cyc();
        redirect = 1'b1; halt = 1'b1;
        #2;
        checks++; if (pc_sel !== 2'd3 || should_br !== 1'b1) begin failures++; $display("FAIL redir_halt: pc_sel=%0d br=%0b want 3 1", pc_sel, should_br); end
        cyc();
        redirect = 1'b0; halt = 1'b0;
        #2;
        checks++; if (pc_sel !== 2'd2 || fetch_valid !== 1'b1) begin failures++; $display("FAIL redir_halt_stays_run: pc_sel=%0d fv=%0b want 2 1", pc_sel, fetch_valid); end
        checks++; if (flush_cnt !== 32'd2 || cycle_cnt !== 32'd3 || inst_cnt !== 32'd1) begin failures++; $display("FAIL redir_halt_counts: flush=%0d cyc=%0d inst=%0d want 2 3 1", flush_cnt, cycle_cnt, inst_cnt); end
    endtask

    task automatic test_halt_resume();
        boot();
        halt = 1'b1;
        #2;
        checks++; if (pc_sel !== 2'd2 || fetch_valid !== 1'b1) begin failures++; $display("FAIL halt_entry_cycle: pc_sel=%0d fv=%0b want 2 1", pc_sel, fetch_valid); end
        for (int i = 0; i < 2; i++) begin
            cyc();
            halt = 1'b0; redirect = 1'b1;
            #2;
            checks++; if (pc_sel !== 2'd1 || should_br !== 1'b0 || fetch_valid !== 1'b0) begin failures++; $display("FAIL halt_ignore_redir: pc_sel=%0d br=%0b fv=%0b want 1 0 0", pc_sel, should_br, fetch_valid); end
        end
        cyc();
        redirect = 1'b0; resume = 1'b1;
        #2;
        checks++; if (pc_sel !== 2'd1) begin failures++; $display("FAIL halt_resume_cycle: pc_sel=%0d want 1", pc_sel); end
        checks++; if (flush_cnt !== 32'd0 || inst_cnt !== 32'd1 || cycle_cnt !== 32'd3) begin failures++; $display("FAIL halt_counts: flush=%0d inst=%0d cyc=%0d want 0 1 3", flush_cnt, inst_cnt, cycle_cnt); end
        cyc();
        resume = 1'b0;
        #2;
        checks++; if (pc_sel !== 2'd2 || fetch_valid !== 1'b1) begin failures++; $display("FAIL halt_after_resume: pc_sel=%0d fv=%0b want 2 1", pc_sel, fetch_valid); end
    endtask

    task automatic test_stall_burst();
        boot();
        for (int i = 0; i < 5; i++) begin
            stall = 1'b1;
            #2;
            checks++; if (pc_sel !== 2'd1 || fetch_valid !== 1'b0) begin failures++; $display("FAIL stall_cycle%0d: pc_sel=%0d fv=%0b want 1 0", i, pc_sel, fetch_valid); end
            cyc();
        end
        stall = 1'b0;
        #2;
        checks++; if (inst_cnt !== 32'd0 || cycle_cnt !== 32'd5) begin failures++; $display("FAIL stall_counts: inst=%0d cyc=%0d want 0 5", inst_cnt, cycle_cnt); end
        checks++; if (pc_sel !== 2'd2) begin failures++; $display("FAIL stall_release: pc_sel=%0d want 2", pc_sel); end
    endtask

    task automatic test_mid_reset();
        boot();
        halt = 1'b1;
        cyc();
        halt = 1'b0;
        rst = 1'b1;
        #2;
        checks++; if (pc_sel !== 2'd0 || fetch_valid !== 1'b0) begin failures++; $display("FAIL rst_in_halt: pc_sel=%0d fv=%0b want 0 0", pc_sel, fetch_valid); end
        checks++; if (inst_cnt !== 32'd1 || cycle_cnt !== 32'd1) begin failures++; $display("FAIL rst_in_halt_pre: inst=%0d cyc=%0d want 1 1", inst_cnt, cycle_cnt); end
        cyc();
        rst = 1'b0;
        #2;
        checks++; if (inst_cnt !== 32'd0 || cycle_cnt !== 32'd0 || flush_cnt !== 32'd0) begin failures++; $display("FAIL rst_in_halt_clear: %0d %0d %0d want 0 0 0", cycle_cnt, inst_cnt, flush_cnt); end
        checks++; if (pc_sel !== 2'd0) begin failures++; $display("FAIL reboot1_c0: pc_sel=%0d want 0", pc_sel); end
        cyc(); #2;
        checks++; if (pc_sel !== 2'd0) begin failures++; $display("FAIL reboot1_c1: pc_sel=%0d want 0", pc_sel); end
        cyc();
        redirect = 1'b1;
        #2;
        checks++; if (pc_sel !== 2'd3) begin failures++; $display("FAIL reboot1_run: pc_sel=%0d want 3", pc_sel); end
        cyc();
        rst = 1'b1;
        #2;
        checks++; if (pc_sel !== 2'd0 || should_br !== 1'b0) begin failures++; $display("FAIL rst_in_redir: pc_sel=%0d br=%0b want 0 0", pc_sel, should_br); end
        checks++; if (flush_cnt !== 32'd1) begin failures++; $display("FAIL rst_in_redir_pre: flush=%0d want 1", flush_cnt); end
        cyc();
        rst = 1'b0; redirect = 1'b0;
        #2;
        checks++; if (flush_cnt !== 32'd0 || cycle_cnt !== 32'd0 || inst_cnt !== 32'd0) begin failures++; $display("FAIL rst_in_redir_clear: %0d %0d %0d want 0 0 0", cycle_cnt, inst_cnt, flush_cnt); end
        checks++; if (pc_sel !== 2'd0) begin failures++; $display("FAIL reboot2_c0: pc_sel=%0d want 0", pc_sel); end
        cyc(); #2;
        checks++; if (pc_sel !== 2'd0) begin failures++; $display("FAIL reboot2_c1: pc_sel=%0d want 0", pc_sel); end
        cyc(); #2;
        checks++; if (pc_sel !== 2'd2 || fetch_valid !== 1'b1) begin failures++; $display("FAIL reboot2_run: pc_sel=%0d fv=%0b want 2 1", pc_sel, fetch_valid); end
    endtask

    task automatic test_counter_wrap();
        redirect4 = 1'b0; stall4 = 1'b0; halt4 = 1'b0; resume4 = 1'b0; clr4 = 1'b0;
        rst4 = 1'b1;
        cyc(); cyc();
        rst4 = 1'b0;
        cyc(); cyc();
        // now in the first RUN cycle; 20 accepted fetches
        for (int i = 0; i < 20; i++) begin
            cyc();
        end
        #2;
        checks++; if (inst_cnt4 !== 4'd4) begin failures++; $display("FAIL wrap_inst_cnt: got %0d want 4", inst_cnt4); end
        checks++; if (cycle_cnt4 !== 4'd4 || flush_cnt4 !== 4'd0) begin failures++; $display("FAIL wrap_other: cyc=%0d flush=%0d want 4 0", cycle_cnt4, flush_cnt4); end
        clr4 = 1'b1;
        #2;
        checks++; if (fetch_valid4 !== 1'b1) begin failures++; $display("FAIL clr_inc_same_cycle: fv=%0b want 1", fetch_valid4); end
        cyc();
        clr4 = 1'b0;
        #2;
        checks++; if (inst_cnt4 !== 4'd0 || cycle_cnt4 !== 4'd0 || flush_cnt4 !== 4'd0) begin failures++; $display("FAIL clr_result: %0d %0d %0d want 0 0 0", cycle_cnt4, inst_cnt4, flush_cnt4); end
        cyc(); #2;
        checks++; if (inst_cnt4 !== 4'd1 || pc_sel4 !== 2'd2) begin failures++; $display("FAIL clr_state_kept: inst=%0d pc_sel=%0d want 1 2", inst_cnt4, pc_sel4); end
    endtask

    initial begin
        rst = 1'b1;
        rst4 = 1'b1;
        redirect4 = 1'b0; stall4 = 1'b0; halt4 = 1'b0; resume4 = 1'b0; clr4 = 1'b0;
        idle_inputs();
        test_reset();
        test_redirect_vs_stall();
        test_halt_resume();
        test_stall_burst();
        test_mid_reset();
        test_counter_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fetch_ctrl
